// File: rtl/i2c_tx_byte_shifter.sv
// Responder-side I2C transmit shifter: loads a byte on a master read, drives it MSB-first on SDA
// (open-drain, falling SCL edge), then samples the master's ACK. Optional I2C_TX_BYTECOUNT_EN adds tx_count.
module i2c_tx_byte_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              SCL,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_tx,
    input  logic              stop_det,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              tx_busy,
    output logic              tx_done,
`ifdef I2C_TX_BYTECOUNT_EN
    output logic [7:0]        tx_count,
`endif
    output logic              nack_rcvd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_tx_done, w_tx_done_nxt;
    logic              r_nack, w_nack_nxt;

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_done_nxt = 1'b0;
        w_nack_nxt    = 1'b0;
        if (stop_det) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_tx) begin
                        w_shreg_nxt   = data_i;
                        w_bit_cnt_nxt = CNT_W'(DATA_W - 1);
                        w_state_nxt   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == '0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (!sda_i) begin
                        w_tx_done_nxt = 1'b1;
                        // A load at the ACK edge chains the next byte with no idle bit.
                        if (load_tx) begin
                            w_shreg_nxt   = data_i;
                            w_bit_cnt_nxt = CNT_W'(DATA_W - 1);
                            w_state_nxt   = S_SHIFT;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_nack_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge SCL) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx_done <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx_done <= w_tx_done_nxt;
            r_nack    <= w_nack_nxt;
        end
    end

`ifdef I2C_TX_BYTECOUNT_EN
    logic [7:0] r_tx_count;

    // Cleared only by NACK, stop or reset; a clean ACK into IDLE keeps the running count.
    always_ff @(negedge SCL) begin
        if (rst || stop_det || w_nack_nxt) begin
            r_tx_count <= 8'd0;
        end else if (w_tx_done_nxt && r_tx_count != 8'hFF) begin
            r_tx_count <= r_tx_count + 8'd1;
        end
    end

    assign tx_count = r_tx_count;
`endif

    assign sda_oe    = (r_state == S_SHIFT) && !r_shreg[DATA_W-1];
    assign tx_busy   = (r_state != S_IDLE);
    assign tx_done   = r_tx_done;
    assign nack_rcvd = r_nack;

endmodule

// File: tb/tb_i2c_tx_byte_shifter.sv
// Scoreboard bench for i2c_tx_byte_shifter: stimulus pushes the expected outputs for each falling
// SCL edge, a monitor pops and compares on the following rising edge.
module tb_i2c_tx_byte_shifter;

    typedef struct packed {
        logic       oe;
        logic       busy;
        logic       done;
        logic       nack;
        logic [7:0] cnt;
    } exp_t;

    logic       SCL = 1'b1;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       load_tx = 1'b0;
    logic       stop_det = 1'b0;
    logic       sda_i = 1'b1;
    logic       sda_oe, tx_busy, tx_done, nack_rcvd;
`ifdef I2C_TX_BYTECOUNT_EN
    logic [7:0] tx_count;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic [7:0] exp_cnt = 8'd0;

    i2c_tx_byte_shifter #(.DATA_W(8)) dut (
        .SCL      (SCL),
        .rst      (rst),
        .data_i   (data_i),
        .load_tx  (load_tx),
        .stop_det (stop_det),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
`ifdef I2C_TX_BYTECOUNT_EN
        .tx_count (tx_count),
`endif
        .nack_rcvd(nack_rcvd)
    );

    always #5 SCL = ~SCL;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: the rising edge after each active falling edge.
    always @(posedge SCL) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("sda_oe@%0d", cyc), {7'd0, sda_oe}, {7'd0, e.oe});
            check($sformatf("tx_busy@%0d", cyc), {7'd0, tx_busy}, {7'd0, e.busy});
            check($sformatf("tx_done@%0d", cyc), {7'd0, tx_done}, {7'd0, e.done});
            check($sformatf("nack_rcvd@%0d", cyc), {7'd0, nack_rcvd}, {7'd0, e.nack});
`ifdef I2C_TX_BYTECOUNT_EN
            check($sformatf("tx_count@%0d", cyc), tx_count, e.cnt);
`endif
        end
    end

    // One falling edge of stimulus plus the outputs expected after it.
    task automatic step(input logic r, ld, input logic [7:0] d, input logic stp, sda,
                        input logic e_oe, e_busy, e_done, e_nack);
        exp_t e;
        @(posedge SCL);
        #1;
        rst = r; load_tx = ld; data_i = d; stop_det = stp; sda_i = sda;
        if (r || stp || e_nack) exp_cnt = 8'd0;
        else if (e_done && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e = '{oe: e_oe, busy: e_busy, done: e_done, nack: e_nack, cnt: exp_cnt};
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        step(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    endtask

    // Load edge: first bit driven immediately.
    task automatic load_edge(input logic [7:0] d);
        step(0, 1, d, 0, 1, ~d[7], 1, 0, 0);
    endtask

    // Bits 1..7 (load_tx noise must be ignored), then the edge into the ACK slot.
    task automatic shift_rest(input logic [7:0] d, input logic ld_noise);
        for (int i = 1; i < 8; i++) step(0, ld_noise, 8'hC3, 0, 1, ~d[7-i], 1, 0, 0);
        step(0, ld_noise, 8'hC3, 0, 1, 0, 1, 0, 0);
    endtask

    task automatic ack_slot(input logic sda, input logic ld, input logic [7:0] nd);
        if (sda) step(0, ld, nd, 0, 1, 0, 0, 0, 1);
        else if (ld) step(0, 1, nd, 0, 0, ~nd[7], 1, 1, 0);
        else step(0, 0, nd, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        // 1: reset over two edges
        step(1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        step(1, 1, 8'hFF, 0, 1, 0, 0, 0, 0);
        idle_cycle();

        // 2: 0xA5 with master ACK, load_tx toggled during SHIFT
        load_edge(8'hA5);
        shift_rest(8'hA5, 1);
        ack_slot(0, 0, 8'h00);
        idle_cycle();

        // 3: 0x3C NACKed; load_tx at the NACK edge is ignored
        load_edge(8'h3C);
        shift_rest(8'h3C, 0);
        ack_slot(1, 1, 8'h55);
        idle_cycle();

        // 4: chained 0xFF then 0x00 with no idle bit
        load_edge(8'hFF);
        shift_rest(8'hFF, 0);
        ack_slot(0, 1, 8'h00);
        shift_rest(8'h00, 0);
        ack_slot(0, 0, 8'h00);
        idle_cycle();

        // 5: stop_det at bit 4 of 0x81
        load_edge(8'h81);
        for (int i = 1; i < 4; i++) step(0, 0, 8'h00, 0, 1, ~data_bit(8'h81, 7 - i), 1, 0, 0);
        step(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        idle_cycle();

        // 6: stop_det beats load_tx in IDLE; reset mid-byte releases SDA
        step(0, 1, 8'h00, 1, 1, 0, 0, 0, 0);
        idle_cycle();
        load_edge(8'h00);
        step(0, 0, 8'h00, 0, 1, 1, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 1, 1, 0, 0);
        step(1, 1, 8'h00, 0, 1, 0, 0, 0, 0);
        idle_cycle();
        idle_cycle();

        repeat (3) @(posedge SCL);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic data_bit(input logic [7:0] d, input int idx);
        return d[idx];
    endfunction

endmodule
